// File: rtl/burst_pi_filter.sv
// rtl/burst_pi_filter.sv - burst-gated PI loop filter driving the colour-burst NCO offset
// Optional lock detector is built when BURST_PI_LOCK_DET_EN is defined.
module burst_pi_filter #(
    parameter int ERR_W       = 12,
    parameter int ACC_W       = 32,
    parameter int OUT_W       = 32,
    parameter int CNT_W       = 7,
    parameter int MIN_SAMPLES = 8,
    parameter int INT_LIMIT   = 2**24,
    parameter int LOCK_THRESH = 64,
    parameter int LOCK_LINES  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             burst_active,
    input  logic [ERR_W-1:0] error_in,
    input  logic [4:0]       kp_shift,
    input  logic [4:0]       ki_shift,
    input  logic             freeze,
    output logic [OUT_W-1:0] offset_out,
    output logic             offset_valid,
    output logic             runt_burst,
    output logic             locked
);

    localparam logic [CNT_W-1:0]        CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]        MIN_CNT = CNT_W'(MIN_SAMPLES);
    localparam logic signed [ACC_W:0]   LIM_POS = (ACC_W+1)'(INT_LIMIT);
    localparam logic signed [ACC_W:0]   LIM_NEG = -LIM_POS;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] cap_err;
    logic signed [ACC_W-1:0] integ;
    logic signed [ACC_W-1:0] err_ext;
    logic signed [ACC_W-1:0] p_term;
    logic signed [ACC_W-1:0] i_term;
    logic signed [ACC_W-1:0] int_next;
    logic signed [ACC_W:0]   int_sum;
    logic signed [ACC_W:0]   out_sum;
    logic [ACC_W-OUT_W+1:0]  out_hi;
    logic [OUT_W-1:0]        out_sat;
    logic [CNT_W-1:0]        cnt;
    logic                    upd;

    always_comb begin
        err_ext = ACC_W'($signed(error_in));
        p_term  = cap_err >>> kp_shift;
        i_term  = integ >>> ki_shift;
        // One guard bit so the clamp sees the true sum before it could wrap
        int_sum = (ACC_W+1)'(integ) + (ACC_W+1)'(cap_err);
        if (int_sum > LIM_POS) begin
            int_next = LIM_POS[ACC_W-1:0];
        end else if (int_sum < LIM_NEG) begin
            int_next = LIM_NEG[ACC_W-1:0];
        end else begin
            int_next = int_sum[ACC_W-1:0];
        end
        out_sum = (ACC_W+1)'(p_term) + (ACC_W+1)'(i_term);
        // Fits in OUT_W only if every bit above the output sign bit matches it
        out_hi  = out_sum[ACC_W:OUT_W-1];
        if ((&out_hi) || !(|out_hi)) begin
            out_sat = out_sum[OUT_W-1:0];
        end else if (out_sum[ACC_W]) begin
            out_sat = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            out_sat = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            cnt          <= '0;
            cap_err      <= '0;
            upd          <= 1'b0;
            integ        <= '0;
            offset_out   <= '0;
            offset_valid <= 1'b0;
            runt_burst   <= 1'b0;
        end else begin
            offset_valid <= 1'b0;
            runt_burst   <= 1'b0;
            upd          <= 1'b0;
            if (burst_active) begin
                if (cnt != CNT_MAX) begin
                    acc <= acc + err_ext;
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (cnt != '0) begin
                if (cnt >= MIN_CNT) begin
                    cap_err <= acc;
                    upd     <= 1'b1;
                end else begin
                    runt_burst <= 1'b1;
                end
                acc <= '0;
                cnt <= '0;
            end
            if (upd) begin
                if (!freeze) begin
                    integ <= int_next;
                end
                offset_out   <= out_sat;
                offset_valid <= 1'b1;
            end
        end
    end

`ifdef BURST_PI_LOCK_DET_EN
    localparam int                  SW         = $clog2(LOCK_LINES + 1);
    localparam logic [SW-1:0]       STREAK_MAX = SW'(LOCK_LINES);
    localparam logic [ACC_W:0]      THRESH     = (ACC_W+1)'(LOCK_THRESH);

    logic [SW-1:0]         streak;
    logic [SW-1:0]         streak_next;
    logic signed [ACC_W:0] cap_ext;
    logic [ACC_W:0]        cap_mag;

    always_comb begin
        cap_ext     = (ACC_W+1)'(cap_err);
        cap_mag     = cap_err[ACC_W-1] ? -cap_ext : cap_ext;
        streak_next = (streak == STREAK_MAX) ? streak : streak + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
            locked <= 1'b0;
        end else if (upd) begin
            if (cap_mag < THRESH) begin
                streak <= streak_next;
                if (streak_next == STREAK_MAX) begin
                    locked <= 1'b1;
                end
            end else begin
                streak <= '0;
                locked <= 1'b0;
            end
        end
    end
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_burst_pi_filter.sv
// tb/tb_burst_pi_filter.sv - directed self-checking bench for burst_pi_filter with a line-level model
module tb_burst_pi_filter;

    localparam int OUT_W       = 24;
    localparam int MIN_SAMP    = 8;
    localparam int CNT_CAP     = 127;
    localparam longint INT_LIM = 64'd16777216;
    localparam int LOCK_THRESH = 64;
    localparam int LOCK_LINES  = 16;
`ifdef BURST_PI_LOCK_DET_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        burst_active = 1'b0;
    logic        freeze = 1'b0;
    logic [11:0] error_in = '0;
    logic [4:0]  kp_shift = '0;
    logic [4:0]  ki_shift = '0;
    logic signed [OUT_W-1:0] offset_out;
    logic        offset_valid;
    logic        runt_burst;
    logic        locked;

    always #5 clk = ~clk;

    burst_pi_filter #(.OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .burst_active(burst_active), .error_in(error_in),
        .kp_shift(kp_shift), .ki_shift(ki_shift), .freeze(freeze),
        .offset_out(offset_out), .offset_valid(offset_valid),
        .runt_burst(runt_burst), .locked(locked)
    );

    int     errors = 0;
    int     checks = 0;
    bit     chk_en = 1'b0;
    longint exp_off = 0;
    bit     exp_valid = 1'b0;
    bit     exp_runt = 1'b0;
    bit     exp_lock = 1'b0;
    longint m_integ = 0;
    int     m_streak = 0;
    int     gen = 0;
    longint line_sum = 0;
    int     line_cnt = 0;
    int     nvalid = 0;
    int     nrunt = 0;
    int     nv_snap;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("offset_out", offset_out, exp_off);
            check("offset_valid", offset_valid, exp_valid);
            check("runt_burst", runt_burst, exp_runt);
            check("locked", locked, exp_lock);
            if (offset_valid) nvalid++;
            if (runt_burst) nrunt++;
        end
    end

    function automatic longint sat_out(input longint v);
        longint mx;
        mx = (longint'(1) <<< (OUT_W - 1)) - 1;
        if (v > mx) return mx;
        if (v < -mx - 1) return -mx - 1;
        return v;
    endfunction

    function automatic longint clamp_int(input longint v);
        if (v > INT_LIM) return INT_LIM;
        if (v < -INT_LIM) return -INT_LIM;
        return v;
    endfunction

    function automatic void model_update(input longint s, input int kpv, input int kiv, input bit fz);
        exp_off = sat_out((s >>> kpv) + (m_integ >>> kiv));
        if (!fz) m_integ = clamp_int(m_integ + s);
        if (LOCK_EN) begin
            if (s < LOCK_THRESH && s > -LOCK_THRESH) begin
                if (m_streak < LOCK_LINES) m_streak++;
                if (m_streak == LOCK_LINES) exp_lock = 1'b1;
            end else begin
                m_streak = 0;
                exp_lock = 1'b0;
            end
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input int v);
        @(posedge clk);
        #1;
        burst_active = 1'b1;
        error_in = 12'(v);
        if (line_cnt < CNT_CAP) begin
            line_sum += v;
            line_cnt++;
        end
    endtask

    task automatic drive_burst(input int n, input int v);
        repeat (n) drive_sample(v);
    endtask

    task automatic end_burst();
        longint s;
        int c, g, kpv, kiv;
        bit fz;
        @(posedge clk);
        #1;
        burst_active = 1'b0;
        error_in = '0;
        s = line_sum; c = line_cnt; g = gen;
        kpv = kp_shift; kiv = ki_shift; fz = freeze;
        line_sum = 0; line_cnt = 0;
        fork
            begin
                @(posedge clk);
                #1;
                if (g == gen && c < MIN_SAMP) exp_runt = 1'b1;
                @(posedge clk);
                #1;
                if (g == gen) begin
                    if (c < MIN_SAMP) exp_runt = 1'b0;
                    else begin
                        model_update(s, kpv, kiv, fz);
                        exp_valid = 1'b1;
                    end
                end
                @(posedge clk);
                #1;
                if (g == gen && c >= MIN_SAMP) exp_valid = 1'b0;
            end
        join_none
    endtask

    task automatic line(input int n, input int v);
        drive_burst(n, v);
        end_burst();
        idle(4);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        burst_active = 1'b0;
        gen++;
        @(posedge clk);
        #1;
        exp_off = 0; exp_valid = 1'b0; exp_runt = 1'b0; exp_lock = 1'b0;
        m_integ = 0; m_streak = 0; line_sum = 0; line_cnt = 0;
        repeat (n - 1) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset offset_out", offset_out, 0);
        check("reset locked", locked, 0);

        kp_shift = 5'd4; ki_shift = 5'd8;
        line(20, 10);
        check("kp4 line offset", offset_out, 12);
        check("kp4 line pulses", nvalid, 1);

        line(5, 7);
        check("runt pulses", nrunt, 1);
        check("runt no update", nvalid, 1);
        check("runt offset held", offset_out, 12);

        kp_shift = 5'd0; ki_shift = 5'd31;
        drive_burst(10, 100);
        do_reset(2);
        check("mid-burst reset offset", offset_out, 0);
        drive_burst(12, 3);
        end_burst();
        idle(4);
        check("post-reset sum", offset_out, 36);

        freeze = 1'b1; kp_shift = 5'd0; ki_shift = 5'd2;
        for (int k = 0; k < 3; k++) begin
            line(20, -50);
            check("freeze offset", offset_out, -991);
        end
        freeze = 1'b0;

        kp_shift = 5'd1; ki_shift = 5'd1;
        drive_burst(8, -3);
        end_burst();
        drive_burst(10, 5);
        end_burst();
        idle(4);
        check("back-to-back offset", offset_out, 31);

        kp_shift = 5'd31; ki_shift = 5'd31;
        line(8, -3);
        check("max shift sign fill", offset_out, -1);

        kp_shift = 5'd0; ki_shift = 5'd31;
        line(130, 1);
        check("count saturation", offset_out, 127);

        nv_snap = nvalid;
        drive_burst(10, 1);
        end_burst();
        do_reset(2);
        idle(4);
        check("reset E0-E1 no pulse", nvalid, nv_snap);
        check("reset E0-E1 offset", offset_out, 0);

        kp_shift = 5'd0; ki_shift = 5'd31;
        for (int k = 0; k < 15; k++) line(10, 1);
        check("lock after 15", locked, 0);
        line(10, 1);
        check("lock after 16", locked, LOCK_EN);
        line(10, 10);
        check("lock after big line", locked, 0);

        kp_shift = 5'd0; ki_shift = 5'd0;
        for (int k = 0; k < 200; k++) line(100, 2047);
        check("output saturation", offset_out, 8388607);
        ki_shift = 5'd2;
        line(8, 0);
        check("integrator clamp", offset_out, 4194304);
        check("total updates", nvalid, 227);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
